// File: rtl/waveform_shaper.sv
// Waveform shaper: turns a DDS phase/sine stream into sine, trapezoid,
// triangle, sawtooth, square or DC samples with gain and saturation.
// Four register stages; config is shadowed and only swapped at a phase wrap.
module waveform_shaper #(
  parameter int PHASE_WIDTH    = 16,
  parameter int SINE_WIDTH     = 16,
  parameter int DAC_WIDTH      = 14,
  parameter int OUT_WIDTH      = 16,
  parameter int CFG_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [SINE_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic [PHASE_WIDTH-1:0]        s_axis_tdata_phase,
  input  logic                          s_axis_tvalid_phase,
  input  logic [CFG_DATA_WIDTH-1:0]     cfg_data,
  output logic signed [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid
);

  localparam int unsigned AW    = DAC_WIDTH + 18;
  localparam int unsigned PW    = DAC_WIDTH + 17;
  localparam int unsigned PSH   = PHASE_WIDTH - DAC_WIDTH;
  localparam int unsigned SSH   = SINE_WIDTH - DAC_WIDTH;
  localparam int          M_INT = (1 << (DAC_WIDTH - 1)) - 1;
  localparam int          H_INT = (1 << (DAC_WIDTH - 2)) - 1;

  localparam logic signed [AW-1:0]        M  = AW'(M_INT);
  localparam logic signed [AW-1:0]        H  = AW'(H_INT);
  localparam logic signed [PW-1:0]        MP = PW'(M_INT);
  localparam logic signed [DAC_WIDTH-1:0] MD = DAC_WIDTH'(M_INT);

  logic                          iv_c, wrap_c;
  logic signed [DAC_WIDTH-1:0]   p_in_c, s_in_c;

  logic                          v1, v2, v3, loaded;
  logic signed [DAC_WIDTH-1:0]   p1, s1, prev_p, shape2;
  logic [3:0]                    cfg_type;
  logic signed [15:0]            cfg_a, cfg_ainc;
  logic [15:0]                   cfg_gain, gain2;
  logic signed [PW-1:0]          prod3;

  logic signed [AW-1:0]          pe_c, se_c, ae_c, ie_c, raw_c;
  logic signed [DAC_WIDTH-1:0]   shape_c, dac_c;
  logic signed [PW-1:0]          prod_c, scaled_c;
  logic                          unused_cfg_c;

  assign unused_cfg_c = ^cfg_data;

  // Input qualification, scaling to DAC width and wrap detection
  assign iv_c   = s_axis_tvalid & s_axis_tvalid_phase;
  assign p_in_c = DAC_WIDTH'($signed(s_axis_tdata_phase) >>> PSH);
  assign s_in_c = DAC_WIDTH'($signed(s_axis_tdata) >>> SSH);
  assign wrap_c = !loaded || (p_in_c[DAC_WIDTH-1] && !prev_p[DAC_WIDTH-1]);

  // Stage 1: capture scaled sample, track previous phase, swap config at wrap
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v1       <= 1'b0;
      p1       <= '0;
      s1       <= '0;
      prev_p   <= '0;
      loaded   <= 1'b0;
      cfg_type <= '0;
      cfg_a    <= '0;
      cfg_ainc <= '0;
      cfg_gain <= '0;
    end else begin
      v1 <= iv_c;
      if (iv_c) begin
        p1     <= p_in_c;
        s1     <= s_in_c;
        prev_p <= p_in_c;
        loaded <= 1'b1;
        if (wrap_c) begin
          cfg_type <= cfg_data[3:0];
          cfg_a    <= $signed(cfg_data[31:16]);
          cfg_ainc <= $signed(cfg_data[47:32]);
          cfg_gain <= cfg_data[63:48];
        end
      end
    end
  end

  // Stage 2 shape selection in wide signed arithmetic, clipped to +/-M
  always_comb begin
    pe_c  = AW'(p1);
    se_c  = AW'(s1);
    ae_c  = AW'(cfg_a);
    ie_c  = AW'(cfg_ainc);
    raw_c = '0;
    case (cfg_type)
      4'd0: raw_c = se_c;
      4'd1: begin
        if ((pe_c > -(M - ae_c)) && (pe_c < -ae_c))     raw_c = -M;
        else if ((pe_c > ae_c) && (pe_c < (M - ae_c)))  raw_c = M;
        else if ((pe_c <= ae_c) && (pe_c >= -ae_c))     raw_c = ie_c * pe_c;
        else if (pe_c <= -(M - ae_c))                   raw_c = -(ie_c * (pe_c + M));
        else if (pe_c >= (M - ae_c))                    raw_c = ie_c * (M - pe_c);
        else                                            raw_c = '0;
      end
      4'd2: begin
        if (pe_c <= -H)      raw_c = -((pe_c + M) <<< 1);
        else if (pe_c >= H)  raw_c = (M - pe_c) <<< 1;
        else                 raw_c = pe_c <<< 1;
      end
      4'd3: raw_c = pe_c;
      4'd4: raw_c = (pe_c < ae_c) ? M : -M;
      4'd5: raw_c = ae_c;
      default: raw_c = '0;
    endcase
    if (raw_c > M)       shape_c = MD;
    else if (raw_c < -M) shape_c = -MD;
    else                 shape_c = DAC_WIDTH'(raw_c);
  end

  // Stage 2 register: shape plus the gain that belongs to this sample
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v2     <= 1'b0;
      shape2 <= '0;
      gain2  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        shape2 <= shape_c;
        gain2  <= cfg_gain;
      end
    end
  end

  // Stage 3 full-precision signed x unsigned product
  assign prod_c = PW'(shape2) * PW'($signed({1'b0, gain2}));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v3    <= 1'b0;
      prod3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) prod3 <= prod_c;
    end
  end

  // Stage 4 Q1.15 rescale and final saturation
  always_comb begin
    scaled_c = prod3 >>> 15;
    if (scaled_c > MP)       dac_c = MD;
    else if (scaled_c < -MP) dac_c = -MD;
    else                     dac_c = DAC_WIDTH'(scaled_c);
  end

  // Output register, sign-extended to output width
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      m_axis_tvalid <= v3;
      if (v3) m_axis_tdata <= OUT_WIDTH'(dac_c);
    end
  end

endmodule

// File: tb/tb_waveform_shaper.sv
// Bench for waveform_shaper: directed scenarios plus random stream,
// compared cycle by cycle against an arithmetic reference model.
module tb_waveform_shaper;

  logic        clk = 1'b0;
  logic        areset;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [15:0] s_axis_tdata_phase;
  logic        s_axis_tvalid_phase;
  logic [63:0] cfg_data;
  logic signed [15:0] m_axis_tdata;
  logic        m_axis_tvalid;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_loaded;
  int          m_prev;
  logic [63:0] m_cfg;
  bit          st_v [1:4];
  int          st_d [1:4];
  int          exp_d;

  waveform_shaper dut (
    .clk                 (clk),
    .areset              (areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tdata_phase  (s_axis_tdata_phase),
    .s_axis_tvalid_phase (s_axis_tvalid_phase),
    .cfg_data            (cfg_data),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk(input int typ, input int a, input int ainc, input int gain);
    logic [63:0] r;
    r        = '0;
    r[3:0]   = typ[3:0];
    r[31:16] = a[15:0];
    r[47:32] = ainc[15:0];
    r[63:48] = gain[15:0];
    return r;
  endfunction

  function automatic logic [63:0] rand_cfg();
    int typ, a, ainc, gain;
    logic [15:0] r16;
    typ = int'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) begin
      r16 = 16'($urandom);
      a   = int'($signed(r16));
    end else begin
      a = int'($urandom_range(0, 5000)) - 500;
    end
    ainc = int'($urandom_range(0, 6)) - 1;
    gain = int'($urandom_range(0, 65535));
    return mk(typ, a, ainc, gain);
  endfunction

  // Output value from the shaping rules, using plain 64-bit arithmetic
  function automatic int model_out(input int p, input int s, input logic [63:0] c);
    longint m, h, a, ainc, sh, r;
    int typ;
    m    = 8191;
    h    = 4095;
    typ  = int'(c[3:0]);
    a    = longint'($signed(c[31:16]));
    ainc = longint'($signed(c[47:32]));
    sh   = 0;
    case (typ)
      0: sh = s;
      1: begin
        if (p > -(m - a) && p < -a)      sh = -m;
        else if (p > a && p < m - a)     sh = m;
        else if (p <= a && p >= -a)      sh = ainc * p;
        else if (p <= -(m - a))          sh = -ainc * (p + m);
        else if (p >= m - a)             sh = ainc * (m - p);
        else                             sh = 0;
      end
      2: begin
        if (p <= -h)      sh = -2 * (p + m);
        else if (p >= h)  sh = 2 * (m - p);
        else              sh = 2 * p;
      end
      3: sh = p;
      4: sh = (p < a) ? m : -m;
      5: sh = a;
      default: sh = 0;
    endcase
    if (sh > m) sh = m;
    if (sh < -m) sh = -m;
    r = (sh * longint'(c[63:48])) >>> 15;
    if (r > m) r = m;
    if (r < -m) r = -m;
    return int'(r);
  endfunction

  task automatic model_reset();
    m_loaded = 0;
    m_prev   = 0;
    m_cfg    = '0;
    exp_d    = 0;
    for (int i = 1; i <= 4; i++) begin
      st_v[i] = 0;
      st_d[i] = 0;
    end
  endtask

  // One clock of stimulus; model advanced, outputs checked after the edge
  task automatic step(input bit sv, input bit pv, input logic [15:0] sd,
                      input logic [15:0] pd, input logic [63:0] c);
    bit nv;
    int nd, p, s;
    s_axis_tvalid       = sv;
    s_axis_tvalid_phase = pv;
    s_axis_tdata        = sd;
    s_axis_tdata_phase  = pd;
    cfg_data            = c;
    nv = sv && pv;
    nd = 0;
    if (nv) begin
      p = int'($signed(pd)) >>> 2;
      s = int'($signed(sd)) >>> 2;
      if (!m_loaded || (p < 0 && m_prev >= 0)) m_cfg = c;
      m_prev   = p;
      m_loaded = 1;
      nd = model_out(p, s, m_cfg);
    end
    for (int i = 4; i > 1; i--) begin
      st_v[i] = st_v[i-1];
      st_d[i] = st_d[i-1];
    end
    st_v[1] = nv;
    st_d[1] = nd;
    if (st_v[4]) exp_d = st_d[4];
    @(posedge clk);
    #1;
    chk("tvalid", int'(m_axis_tvalid), int'(st_v[4]));
    chk("tdata", int'(m_axis_tdata), exp_d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, cfg_data);
  endtask

  task automatic hard_reset();
    areset              = 1'b1;
    s_axis_tvalid       = 1'b0;
    s_axis_tvalid_phase = 1'b0;
    s_axis_tdata        = '0;
    s_axis_tdata_phase  = '0;
    cfg_data            = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    areset = 1'b0;
  endtask

  // Asynchronous one-cycle reset pulse in the middle of a stream
  task automatic reset_pulse();
    #2;
    areset              = 1'b1;
    s_axis_tvalid       = 1'b0;
    s_axis_tvalid_phase = 1'b0;
    #1;
    chk("pulse_tvalid", int'(m_axis_tvalid), 0);
    chk("pulse_tdata", int'(m_axis_tdata), 0);
    model_reset();
    @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    logic [63:0] c0, c3, rc;
    logic [15:0] ph;

    // basic sine pass-through
    hard_reset();
    c0 = mk(0, 0, 0, 16'h8000);
    step(1, 1, 16'h1000, 16'h0100, c0);
    chk("lat_n1", int'(m_axis_tvalid), 0);
    idle(3);
    chk("sine_valid", int'(m_axis_tvalid), 1);
    chk("sine_data", int'(m_axis_tdata), 1024);
    idle(1);
    chk("sine_hold", int'(m_axis_tdata), 1024);

    // triangle
    hard_reset();
    rc = mk(2, 0, 0, 16'h8000);
    step(1, 1, 16'($urandom), 16'h4000, rc);
    step(1, 1, 16'($urandom), 16'h1000, rc);
    idle(2);
    chk("tri_4096", int'(m_axis_tdata), 8190);
    idle(1);
    chk("tri_1024", int'(m_axis_tdata), 2048);

    // sawtooth saturation, wrap loads new gain
    hard_reset();
    step(1, 1, 16'h0, 16'h7D00, mk(3, 0, 0, 16'hC000));
    step(1, 1, 16'h0, 16'h8000, mk(3, 0, 0, 16'h8000));
    idle(2);
    chk("saw_sat_pos", int'(m_axis_tdata), 8191);
    idle(1);
    chk("saw_sat_neg", int'(m_axis_tdata), -8191);

    // config change mid-period takes effect only at the wrap
    hard_reset();
    c3 = mk(3, 0, 0, 16'h8000);
    for (int k = 0; k < 32; k++)
      step(1, 1, 16'($urandom), 16'(k * 16'h0400), (k < 10) ? c0 : c3);
    step(1, 1, 16'($urandom), 16'h7FFC, c3);
    step(1, 1, 16'($urandom), 16'h8000, c3);
    step(1, 1, 16'($urandom), 16'h8400, c3);
    step(1, 1, 16'($urandom), 16'h8800, c3);
    step(1, 1, 16'($urandom), 16'h8C00, c3);
    chk("wrap_sample", int'(m_axis_tdata), -8191);
    idle(1);
    chk("after_wrap", int'(m_axis_tdata), (16'h8400 >>> 0) == 16'h8400 ? -7936 : 0);

    // valid gap of three cycles on the phase channel
    hard_reset();
    ph = 16'h0100;
    for (int k = 0; k < 14; k++) begin
      step(1, !(k >= 4 && k <= 6), 16'($urandom), ph, c0);
      ph = ph + 16'h0200;
    end
    idle(4);

    // reset pulse mid-stream; config reloads without a wrap
    for (int k = 0; k < 5; k++) step(1, 1, 16'($urandom), 16'(16'h0400 + k * 16'h0100), c0);
    reset_pulse();
    step(1, 1, 16'h1234, 16'h0800, c3);
    idle(3);
    chk("reload_after_rst", int'(m_axis_tdata), 512);

    // randomized stream
    hard_reset();
    ph = 16'h0;
    rc = mk(0, 0, 0, 16'h8000);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) rc = rand_cfg();
      ph = ph + 16'($urandom_range(0, 16'h0C00));
      if ($urandom_range(0, 49) == 0) ph = 16'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, 16'($urandom), ph, rc);
      if (i == 700) reset_pulse();
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
